// File: rtl/vxe_pipe_arb.sv
`default_nettype none
// ============================================================================
//  Module   : vxe_pipe_arb
//  Purpose  : Two-requester round-robin arbiter feeding an in-order pipe,
//             with a tag FIFO that routes pipe results back to the requester.
//  Revision : 1.0  initial release
// ============================================================================
module vxe_pipe_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_en,
    output logic                  o_busy,
    output logic                  o_err,
    input  logic [DATA_WIDTH-1:0] i_req0_data,
    input  logic                  i_req0_vld,
    output logic                  o_req0_rdy,
    input  logic [DATA_WIDTH-1:0] i_req1_data,
    input  logic                  i_req1_vld,
    output logic                  o_req1_rdy,
    output logic [DATA_WIDTH-1:0] o_pipe_data,
    output logic                  o_pipe_vld,
    input  logic [DATA_WIDTH-1:0] i_pipe_data,
    input  logic                  i_pipe_vld,
    output logic [DATA_WIDTH-1:0] o_rsp0_data,
    output logic                  o_rsp0_vld,
    output logic [DATA_WIDTH-1:0] o_rsp1_data,
    output logic                  o_rsp1_vld
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(TAG_DEPTH);

    logic [TAG_DEPTH-1:0]  r_tag_mem;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_prio;
    logic                  r_pipe_vld;
    logic [DATA_WIDTH-1:0] r_pipe_data;
    logic                  r_err;

    logic w_can_issue;
    logic w_elig0;
    logic w_elig1;
    logic w_grant0;
    logic w_grant1;
    logic w_push;
    logic w_empty;
    logic w_pop;
    logic w_head;

    // Full blocks issue outright; a pop in the same cycle does not free a slot.
    // nrst gating keeps the accept strobes quiet while reset is held.
    assign w_can_issue = i_en & (r_count != c_FULL) & nrst;
    assign w_elig0     = w_can_issue & i_req0_vld;
    assign w_elig1     = w_can_issue & i_req1_vld;
    assign w_grant0    = w_elig0 & (~w_elig1 | ~r_prio);
    assign w_grant1    = w_elig1 & (~w_elig0 |  r_prio);
    assign w_push      = w_grant0 | w_grant1;

    assign w_empty     = (r_count == '0);
    assign w_pop       = i_pipe_vld & ~w_empty;
    assign w_head      = r_tag_mem[r_rd_ptr];

    assign o_req0_rdy  = w_grant0;
    assign o_req1_rdy  = w_grant1;
    assign o_pipe_vld  = r_pipe_vld;
    assign o_pipe_data = r_pipe_data;
    assign o_rsp0_data = i_pipe_data;
    assign o_rsp1_data = i_pipe_data;
    assign o_rsp0_vld  = w_pop & ~w_head;
    assign o_rsp1_vld  = w_pop &  w_head;
    assign o_busy      = ~w_empty;
    assign o_err       = r_err;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tag_mem <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_tag_mem[r_wr_ptr] <= w_grant1;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_prio      <= 1'b0;
            r_pipe_vld  <= 1'b0;
            r_pipe_data <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_grant0) begin
                r_prio <= 1'b1;
            end else if (w_grant1) begin
                r_prio <= 1'b0;
            end
            r_pipe_vld <= w_push;
            if (w_push) begin
                r_pipe_data <= w_grant1 ? i_req1_data : i_req0_data;
            end
            // A return with nothing outstanding is unrecoverable until reset.
            if (i_pipe_vld && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
